// File: rtl/id_ex_reg_pkg.sv
// id_ex_reg_pkg: shared pipeline types for the decode->execute register and its forwarding muxes.
package id_ex_reg_pkg;
  localparam int XLEN = 64;
  localparam int REG_AW = 5;
  typedef logic [XLEN-1:0] u64;
  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alufunc_t;
  typedef struct packed {
    u64       pc;
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    u64       rs1_data;
    u64       rs2_data;
    u64       imm;
    logic     a_pc;
    logic     b_imm;
    alufunc_t alufunc;
    logic     wen;
    logic     memread;
  } decoded_instr_t;
  typedef struct packed {
    logic     wen;
    reg_idx_t rd;
    u64       data;
  } fwd_t;
  localparam fwd_t NO_FWD = '0;
  // MEM is the younger producer, so it beats WB; x0 is never forwarded
  function automatic u64 fwd_sel(reg_idx_t idx, u64 data, fwd_t mem, fwd_t wb);
    return (idx != '0 && mem.wen && mem.rd == idx) ? mem.data :
           (idx != '0 && wb.wen && wb.rd == idx) ? wb.data : data;
  endfunction
endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// id_ex_reg_fwd_mux: selects the freshest value of one source register from MEM, WB or stored data.
module id_ex_reg_fwd_mux import id_ex_reg_pkg::*; (
  input  reg_idx_t idx,
  input  u64       data,
  input  fwd_t     mem,
  input  fwd_t     wb,
  output u64       q
);
  assign q = fwd_sel(idx, data, mem, wb);
endmodule

// File: rtl/id_ex_reg.sv
// id_ex_reg: decode->execute pipeline register with operand forwarding, load-use stall and flush.
module id_ex_reg import id_ex_reg_pkg::*; (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  u64       in_pc,
  input  reg_idx_t in_rs1,
  input  reg_idx_t in_rs2,
  input  reg_idx_t in_rd,
  input  u64       in_rs1_data,
  input  u64       in_rs2_data,
  input  u64       in_imm,
  input  logic     in_a_pc,
  input  logic     in_b_imm,
  input  alufunc_t in_alufunc,
  input  logic     in_wen,
  input  logic     in_memread,
  input  logic     fwd_mem_wen,
  input  reg_idx_t fwd_mem_rd,
  input  u64       fwd_mem_data,
  input  logic     fwd_wb_wen,
  input  reg_idx_t fwd_wb_rd,
  input  u64       fwd_wb_data,
  output logic     out_valid,
  input  logic     out_ready,
  output u64       alu_a,
  output u64       alu_b,
  output alufunc_t alufunc,
  output u64       out_pc,
  output reg_idx_t out_rd,
  output logic     out_wen,
  output logic     out_memread,
  output u64       out_rs2_fwd
);
  decoded_instr_t r;
  logic valid, hazard, fire_in, fire_out;
  fwd_t mem, wb;
  u64 rs1_fwd, rs2_fwd;
  assign mem = '{wen: fwd_mem_wen, rd: fwd_mem_rd, data: fwd_mem_data};
  assign wb  = '{wen: fwd_wb_wen, rd: fwd_wb_rd, data: fwd_wb_data};
  id_ex_reg_fwd_mux u_fwd_rs1 (.idx(r.rs1), .data(r.rs1_data), .mem(mem), .wb(wb), .q(rs1_fwd));
  id_ex_reg_fwd_mux u_fwd_rs2 (.idx(r.rs2), .data(r.rs2_data), .mem(mem), .wb(wb), .q(rs2_fwd));
  always_comb begin
    hazard = valid && r.memread && r.rd != '0 && in_valid &&
             ((in_rs1 != '0 && r.rd == in_rs1) || (in_rs2 != '0 && r.rd == in_rs2));
    in_ready = (!valid || out_ready) && !hazard && !flush;
    fire_in = in_valid && in_ready;
    fire_out = valid && out_ready;
    out_valid = valid;
    alu_a = r.a_pc ? r.pc : rs1_fwd;
    alu_b = r.b_imm ? r.imm : rs2_fwd;
    alufunc = r.alufunc;
    out_pc = r.pc;
    out_rd = r.rd;
    out_wen = r.wen;
    out_memread = r.memread;
    out_rs2_fwd = rs2_fwd;
  end
  // while stalled, latch forwarded values so a producer retiring past WB is not lost
  always_ff @(posedge clk)
    if (reset) begin
      valid <= 1'b0;
      r <= '0;
    end else if (flush) valid <= 1'b0;
    else if (fire_in) begin
      valid <= 1'b1;
      r <= '{pc: in_pc, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
             rs1_data: fwd_sel(in_rs1, in_rs1_data, NO_FWD, wb),
             rs2_data: fwd_sel(in_rs2, in_rs2_data, NO_FWD, wb),
             imm: in_imm, a_pc: in_a_pc, b_imm: in_b_imm, alufunc: in_alufunc,
             wen: in_wen, memread: in_memread};
    end else if (fire_out) valid <= 1'b0;
    else if (valid) begin
      r.rs1_data <= rs1_fwd;
      r.rs2_data <= rs2_fwd;
    end
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, out_wen, out_memread;
  u64 in_pc = 0, in_rs1_data = 0, in_rs2_data = 0, in_imm = 0;
  reg_idx_t in_rs1 = 0, in_rs2 = 0, in_rd = 0;
  logic in_a_pc = 0, in_b_imm = 0, in_wen = 0, in_memread = 0;
  alufunc_t in_alufunc = ALU_ADD;
  logic fwd_mem_wen = 0, fwd_wb_wen = 0;
  reg_idx_t fwd_mem_rd = 0, fwd_wb_rd = 0;
  u64 fwd_mem_data = 0, fwd_wb_data = 0;
  u64 alu_a, alu_b, out_pc, out_rs2_fwd;
  alufunc_t alufunc;
  reg_idx_t out_rd;
  typedef struct packed {u64 pc; u64 a; u64 b; u64 r2; reg_idx_t rd; alufunc_t f;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_a_pc(in_a_pc), .in_b_imm(in_b_imm), .in_alufunc(in_alufunc), .in_wen(in_wen),
    .in_memread(in_memread), .fwd_mem_wen(fwd_mem_wen), .fwd_mem_rd(fwd_mem_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_wen(fwd_wb_wen), .fwd_wb_rd(fwd_wb_rd),
    .fwd_wb_data(fwd_wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alufunc(alufunc), .out_pc(out_pc), .out_rd(out_rd),
    .out_wen(out_wen), .out_memread(out_memread), .out_rs2_fwd(out_rs2_fwd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input u64 act, input u64 exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input u64 pc, input reg_idx_t rs1, input reg_idx_t rs2, input reg_idx_t rd,
                       input u64 d1, input u64 d2, input u64 imm, input logic a_pc,
                       input logic b_imm, input alufunc_t f, input logic wen, input logic mr);
    in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_a_pc = a_pc; in_b_imm = b_imm;
    in_alufunc = f; in_wen = wen; in_memread = mr;
  endtask

  task automatic push(input u64 pc, input u64 a, input u64 b, input u64 r2, input reg_idx_t rd,
                      input alufunc_t f);
    q.push_back('{pc: pc, a: a, b: b, r2: r2, rd: rd, f: f});
  endtask

  // monitor: every accepted output must match the oldest expected transaction
  initial forever begin
    @(negedge clk);
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out_pc", out_pc, '1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_alu_a", alu_a, e.a);
        chk("sb_alu_b", alu_b, e.b);
        chk("sb_rs2_fwd", out_rs2_fwd, e.r2);
        chk("sb_rd", u64'(out_rd), u64'(e.rd));
        chk("sb_alufunc", u64'(alufunc), u64'(e.f));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", u64'(out_valid), 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_in_ready", u64'(in_ready), 1);
    end
    step();
    reset = 0;
    // 1: addi x1,x0,5
    drive(64'h100, 0, 0, 1, 0, 0, 5, 0, 1, ALU_ADD, 1, 0);
    push(64'h100, 0, 5, 0, 1, ALU_ADD);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("addi_out_valid", u64'(out_valid), 1);
    chk("addi_alu_a", alu_a, 0);
    chk("addi_alu_b", alu_b, 5);
    step();
    // 2: held rs1=x3, forwarding priority and refresh
    out_ready = 0;
    drive(64'h104, 3, 0, 4, 64'h10, 0, 1, 0, 1, ALU_ADD, 1, 0);
    step();
    in_valid = 0;
    fwd_mem_wen = 1; fwd_mem_rd = 3; fwd_mem_data = 64'h99;
    fwd_wb_wen = 1; fwd_wb_rd = 3; fwd_wb_data = 64'h55;
    @(negedge clk);
    chk("fwd_mem_wins", alu_a, 64'h99);
    step();
    fwd_mem_wen = 0;
    @(negedge clk);
    chk("fwd_wb", alu_a, 64'h55);
    step();
    fwd_wb_wen = 0;
    out_ready = 1;
    push(64'h104, 64'h55, 1, 0, 4, ALU_ADD);
    @(negedge clk);
    chk("fwd_refresh_kept", alu_a, 64'h55);
    step();
    fwd_mem_wen = 1; fwd_mem_rd = 0; fwd_mem_data = 64'hdead;
    fwd_wb_wen = 1; fwd_wb_rd = 0; fwd_wb_data = 64'hbeef;
    drive(64'h108, 0, 0, 5, 0, 0, 2, 0, 1, ALU_ADD, 1, 0);
    push(64'h108, 0, 2, 0, 5, ALU_ADD);
    step();
    in_valid = 0;
    @(negedge clk);
    chk("x0_no_fwd", alu_a, 0);
    step();
    fwd_mem_wen = 0; fwd_wb_wen = 0;
    // 3: ld x5 then add x6,x5,x1 -> one bubble
    drive(64'h10c, 1, 0, 5, 64'h1000, 0, 8, 0, 1, ALU_ADD, 1, 1);
    push(64'h10c, 64'h1000, 8, 0, 5, ALU_ADD);
    step();
    drive(64'h110, 5, 1, 6, 64'h20, 64'h30, 0, 0, 0, ALU_ADD, 1, 0);
    @(negedge clk);
    chk("ld_memread", u64'(out_memread), 1);
    chk("ld_use_stall", u64'(in_ready), 0);
    step();
    fwd_mem_wen = 1; fwd_mem_rd = 5; fwd_mem_data = 64'h777;
    @(negedge clk);
    chk("bubble_out_valid", u64'(out_valid), 0);
    chk("bubble_in_ready", u64'(in_ready), 1);
    step();
    in_valid = 0;
    fwd_mem_wen = 0;
    fwd_wb_wen = 1; fwd_wb_rd = 5; fwd_wb_data = 64'h777;
    push(64'h110, 64'h777, 64'h30, 64'h30, 6, ALU_ADD);
    step();
    fwd_wb_wen = 0;
    drive(64'h114, 1, 0, 0, 64'h2000, 0, 0, 0, 1, ALU_ADD, 1, 1);
    push(64'h114, 64'h2000, 0, 0, 0, ALU_ADD);
    step();
    drive(64'h118, 0, 0, 7, 0, 0, 0, 0, 0, ALU_ADD, 1, 0);
    push(64'h118, 0, 0, 0, 7, ALU_ADD);
    @(negedge clk);
    chk("ld_x0_no_stall", u64'(in_ready), 1);
    step();
    in_valid = 0;
    step();
    // 4: stall 4 cycles, rs2=x2 forwarded only on the first
    out_ready = 0;
    drive(64'h11c, 0, 2, 8, 0, 1, 0, 0, 0, ALU_SUB, 1, 0);
    step();
    in_valid = 0;
    fwd_mem_wen = 1; fwd_mem_rd = 2; fwd_mem_data = 64'h7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall_alu_b_%0d", i), alu_b, 64'h7);
      chk($sformatf("stall_in_ready_%0d", i), u64'(in_ready), 0);
      step();
      fwd_mem_wen = 0;
    end
    out_ready = 1;
    push(64'h11c, 0, 64'h7, 64'h7, 8, ALU_SUB);
    step();
    // 5: flush kills held and incoming instruction
    out_ready = 0;
    drive(64'h120, 0, 0, 9, 0, 0, 64'h11, 0, 1, ALU_OR, 1, 0);
    step();
    drive(64'h124, 0, 0, 10, 0, 0, 64'h22, 0, 1, ALU_OR, 1, 0);
    flush = 1;
    @(negedge clk);
    chk("flush_in_ready", u64'(in_ready), 0);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("flush_out_valid", u64'(out_valid), 0);
    step();
    // 6: back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(64'h200 + 4 * i, 0, 0, reg_idx_t'(11 + i), 0, 0, 3 * i + 1, 0, 1, ALU_XOR, 1, 0);
      push(64'h200 + 4 * i, 0, 3 * i + 1, 0, reg_idx_t'(11 + i), ALU_XOR);
      @(negedge clk);
      chk($sformatf("stream_in_ready_%0d", i), u64'(in_ready), 1);
      if (i > 0) chk($sformatf("stream_out_valid_%0d", i), u64'(out_valid), 1);
      step();
    end
    in_valid = 0;
    step();
    // reset during a stall empties the register
    out_ready = 0;
    drive(64'h300, 0, 0, 3, 0, 0, 1, 0, 1, ALU_ADD, 1, 0);
    step();
    in_valid = 0;
    reset = 1;
    step();
    reset = 0;
    out_ready = 1;
    @(negedge clk);
    chk("reset_stall_out_valid", u64'(out_valid), 0);
    step();
    chk("scoreboard_drained", u64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
